// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and default timing for the stopwatch sequencer
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam int DEF_TICK_DIV       = 500000;
    localparam int DEF_LONG_PRESS_CYC = 50000000;

endpackage

// File: rtl/stopwatch_key_edge.sv
// rtl/stopwatch_key_edge.sv - falling-edge press detector with optional long-press timer
module key_edge
    import stopwatch_pkg::*;
#(
    parameter bit LONG_EN        = 1'b0,
    parameter int LONG_W         = 26,
    parameter int LONG_PRESS_CYC = DEF_LONG_PRESS_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press,
    output logic long_press
);

    logic hist;
    logic armed;

    // armed stays low for the first edge after reset so a key held through reset is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= 1'b1;
            armed <= 1'b0;
        end else begin
            hist  <= key_n;
            armed <= 1'b1;
        end
    end

    assign press = armed & hist & ~key_n;

    generate
        if (LONG_EN) begin : g_long
            localparam logic [LONG_W-1:0] FIRE_CNT = LONG_W'(LONG_PRESS_CYC - 1);
            localparam logic [LONG_W-1:0] SAT_CNT  = LONG_W'(LONG_PRESS_CYC);

            logic [LONG_W-1:0] long_cnt;

            // saturating one past the fire count keeps the event to a single cycle per hold
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    long_cnt <= '0;
                end else if (key_n) begin
                    long_cnt <= '0;
                end else if (long_cnt != SAT_CNT) begin
                    long_cnt <= long_cnt + 1'b1;
                end
            end

            assign long_press = ~key_n & (long_cnt == FIRE_CNT);
        end else begin : g_no_long
            assign long_press = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch sequencer: key FSM, 10 ms tick prescaler and counter/display controls
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int TICK_W         = 20,
    parameter int LONG_PRESS_CYC = DEF_LONG_PRESS_CYC,
    parameter int LONG_W         = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    input  logic       key_clr_n,
    output logic       tick,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       disp_freeze,
    output logic [1:0] state
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic press_start;
    logic press_lap;
    logic press_clr;
    logic long_clr;
    logic unused_long_start;
    logic unused_long_lap;

    sw_state_t         state_q, state_d;
    logic              cnt_clr_d;
    logic              cnt_en_d;
    logic              disp_freeze_d;
    logic              tick_d;
    logic [TICK_W-1:0] presc_q, presc_d;

    key_edge #(
        .LONG_EN        (1'b0),
        .LONG_W         (LONG_W),
        .LONG_PRESS_CYC (LONG_PRESS_CYC)
    ) u_key_start (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_start_n),
        .press      (press_start),
        .long_press (unused_long_start)
    );

    key_edge #(
        .LONG_EN        (1'b0),
        .LONG_W         (LONG_W),
        .LONG_PRESS_CYC (LONG_PRESS_CYC)
    ) u_key_lap (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_lap_n),
        .press      (press_lap),
        .long_press (unused_long_lap)
    );

    key_edge #(
        .LONG_EN        (1'b1),
        .LONG_W         (LONG_W),
        .LONG_PRESS_CYC (LONG_PRESS_CYC)
    ) u_key_clr (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_clr_n),
        .press      (press_clr),
        .long_press (long_clr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_en      <= 1'b0;
            cnt_clr     <= 1'b0;
            disp_freeze <= 1'b0;
            tick        <= 1'b0;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_en      <= cnt_en_d;
            cnt_clr     <= cnt_clr_d;
            disp_freeze <= disp_freeze_d;
            tick        <= tick_d;
            presc_q     <= presc_d;
        end
    end

    // one event per cycle in priority order: long clear, start, lap, short clear
    always_comb begin
        state_d   = state_q;
        cnt_clr_d = 1'b0;
        if (long_clr) begin
            state_d   = IDLE;
            cnt_clr_d = 1'b1;
        end else if (press_start) begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                LAP:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end else if (press_lap) begin
            unique case (state_q)
                RUN:     state_d = LAP;
                LAP:     state_d = RUN;
                default: state_d = state_q;
            endcase
        end else if (press_clr) begin
            if (state_q == IDLE || state_q == PAUSE) begin
                state_d   = IDLE;
                cnt_clr_d = 1'b1;
            end
        end
    end

    // prescaler follows the next-state enable so tick can never coincide with a stopped counter
    always_comb begin
        cnt_en_d      = (state_d == RUN) || (state_d == LAP);
        disp_freeze_d = (state_d == LAP);
        presc_d       = presc_q;
        tick_d        = 1'b0;
        if (cnt_clr_d) begin
            presc_d = '0;
        end else if (cnt_en_d) begin
            if (presc_q == TICK_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - randomized self-checking bench for stopwatch_ctrl against a behavioural model
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int LP = 10;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_start_n, key_lap_n, key_clr_n;
    logic       tick, cnt_en, cnt_clr, disp_freeze;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    int m_state, m_phase, m_hold;
    bit m_armed, m_ps, m_pl, m_pc, m_tick, m_clr;

    bit r_s, r_l, r_c;

    stopwatch_ctrl #(
        .TICK_DIV       (TD),
        .TICK_W         (3),
        .LONG_PRESS_CYC (LP),
        .LONG_W         (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_start_n (key_start_n),
        .key_lap_n   (key_lap_n),
        .key_clr_n   (key_clr_n),
        .tick        (tick),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .disp_freeze (disp_freeze),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got {st,en,clr,tick,frz}=%b want %b", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = S_IDLE;
        m_phase = 0;
        m_hold  = 0;
        m_armed = 1'b0;
        m_ps    = 1'b1;
        m_pl    = 1'b1;
        m_pc    = 1'b1;
        m_tick  = 1'b0;
        m_clr   = 1'b0;
    endfunction

    function automatic void model_step(input bit s, input bit l, input bit c);
        bit ps, pl, pc, lng, run;
        ps = m_armed && m_ps && !s;
        pl = m_armed && m_pl && !l;
        pc = m_armed && m_pc && !c;
        if (!c) m_hold++;
        else    m_hold = 0;
        lng   = !c && (m_hold == LP);
        m_clr = 1'b0;
        if (lng) begin
            m_state = S_IDLE;
            m_clr   = 1'b1;
        end else if (ps) begin
            m_state = (m_state == S_RUN || m_state == S_LAP) ? S_PAUSE : S_RUN;
        end else if (pl) begin
            if (m_state == S_RUN)      m_state = S_LAP;
            else if (m_state == S_LAP) m_state = S_RUN;
        end else if (pc && (m_state == S_IDLE || m_state == S_PAUSE)) begin
            m_state = S_IDLE;
            m_clr   = 1'b1;
        end
        run    = (m_state == S_RUN) || (m_state == S_LAP);
        m_tick = 1'b0;
        if (m_clr) begin
            m_phase = 0;
        end else if (run) begin
            m_phase++;
            if (m_phase == TD) begin
                m_phase = 0;
                m_tick  = 1'b1;
            end
        end
        m_armed = 1'b1;
        m_ps = s;
        m_pl = l;
        m_pc = c;
    endfunction

    function automatic logic [5:0] model_expect();
        logic [1:0] st;
        st = 2'(m_state);
        return {st, (m_state == S_RUN || m_state == S_LAP), m_clr, m_tick, (m_state == S_LAP)};
    endfunction

    task automatic cycle(input bit s, input bit l, input bit c, input string tag);
        key_start_n = s;
        key_lap_n   = l;
        key_clr_n   = c;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(s, l, c);
        #1;
        check(tag, {state, cnt_en, cnt_clr, tick, disp_freeze}, model_expect());
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check(tag, {state, cnt_en, cnt_clr, tick, disp_freeze}, 6'b0);
        model_reset();
        cycle(1'b1, 1'b1, 1'b1, tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        key_clr_n   = 1'b1;
        model_reset();

        // start held through reset release must not count as a press
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, "rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, "held_start");
        idle(2, "held_release");
        check("held_idle", {state, 4'b0}, 6'b0);
        cycle(1'b0, 1'b1, 1'b1, "start_press");
        check("start_run", {state, cnt_en, 3'b0}, {2'd1, 1'b1, 3'b0});
        idle(11, "run_ticks");

        // pause and resume keep the partial tick
        cycle(1'b0, 1'b1, 1'b1, "pause");
        idle(20, "paused");
        cycle(1'b0, 1'b1, 1'b1, "resume");
        idle(6, "resumed");

        // lap toggle
        cycle(1'b1, 1'b0, 1'b1, "lap_in");
        idle(6, "lap_run");
        cycle(1'b1, 1'b0, 1'b1, "lap_out");
        idle(3, "after_lap");

        // simultaneous start and lap from RUN
        cycle(1'b0, 1'b0, 1'b1, "start_lap");
        idle(3, "after_both");

        // short clear from PAUSE
        cycle(1'b1, 1'b1, 1'b0, "short_clr");
        idle(3, "after_clr");

        // long clear from RUN, then keep holding
        cycle(1'b0, 1'b1, 1'b1, "run_again");
        idle(5, "run_again");
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, "long_clr");
        idle(3, "long_release");

        // async reset in LAP
        cycle(1'b0, 1'b1, 1'b1, "to_run");
        cycle(1'b1, 1'b0, 1'b1, "to_lap");
        idle(2, "in_lap");
        async_reset("async_rst");
        idle(3, "post_rst");

        r_s = 1'b1;
        r_l = 1'b1;
        r_c = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r_s = ~r_s;
            if ($urandom_range(0, 9) == 0) r_l = ~r_l;
            if (r_c ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 15) == 0)) r_c = ~r_c;
            cycle(r_s, r_l, r_c, "random");
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
